// File: rtl/rvvi_trace_writer_if.sv
// Record-in / byte-out bundle for rvvi_trace_writer.
// master = record source and byte sink; slave = the writer.
interface rvvi_trace_writer_if #(
    parameter int XLEN = 32,
    parameter int FLEN = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          insn;
    logic [XLEN-1:0]      pc_rdata;
    logic [1:0]           mode;
    logic                 trap;
    logic [31:0]          x_wb;
    logic [32*XLEN-1:0]   x_wdata;
    logic [31:0]          f_wb;
    logic [32*FLEN-1:0]   f_wdata;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_data;
    logic                 out_last;

    modport master (
        output in_valid, insn, pc_rdata, mode, trap, x_wb, x_wdata, f_wb, f_wdata, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
    modport slave (
        input  in_valid, insn, pc_rdata, mode, trap, x_wb, x_wdata, f_wb, f_wdata, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rvvi_trace_writer.sv
// Serializes one RVVI retirement record into one ASCII key/value trace line,
// one byte per cycle under valid/ready.
module rvvi_trace_writer #(
    parameter int XLEN = 32,
    parameter int FLEN = 32
) (
    input logic               clk,
    input logic               reset,
    rvvi_trace_writer_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0, S_KEY = 3'd1, S_SPACE = 3'd2,
                           S_REGNUM = 3'd3, S_VALUE = 3'd4, S_EOL = 3'd5;
    localparam logic [2:0] F_ORDER = 3'd0, F_INSN = 3'd1, F_PC = 3'd2, F_MODE = 3'd3,
                           F_TRAP = 3'd4, F_X = 3'd5, F_F = 3'd6;
    localparam logic [1:0] A_KEY = 2'd0, A_REG = 2'd1, A_VAL = 2'd2;
    localparam logic [3:0] XTOP = 4'(XLEN / 4 - 1);
    localparam logic [3:0] FTOP = 4'(FLEN / 4 - 1);

    logic [2:0]          state_q, state_d, fld_q, fld_d, kidx_q, kidx_d;
    logic [3:0]          didx_q, didx_d;
    logic [1:0]          aft_q, aft_d;
    logic [39:0]         order_q, order_inc;
    logic [31:0]         insn_q, xm_q, xm_d, fm_q, fm_d;
    logic [XLEN-1:0]     pc_q;
    logic [1:0]          mode_q;
    logic                trap_q;
    logic [32*XLEN-1:0]  xd_q;
    logic [32*FLEN-1:0]  fd_q;

    logic        accept, hs;
    logic [4:0]  xreg, freg, rn, ones;
    logic [1:0]  tens;
    logic [3:0]  ord_top, vstart, nib;
    logic [63:0] cur_val;
    logic [31:0] rem_x, rem_f;
    logic [39:0] kstr;
    logic [2:0]  klast;
    logic [7:0]  out_data_c;

    function automatic logic [7:0] hexch(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    assign bus.in_ready  = (state_q == S_IDLE) && !reset;
    assign bus.out_valid = (state_q != S_IDLE);
    assign bus.out_last  = (state_q == S_EOL);
    assign bus.out_data  = out_data_c;
    assign accept        = bus.in_valid && bus.in_ready;
    assign hs            = bus.out_valid && bus.out_ready;

    always_comb begin
        xreg = '0;
        freg = '0;
        for (int i = 31; i >= 0; i--) begin
            if (xm_q[i]) xreg = 5'(i);
            if (fm_q[i]) freg = 5'(i);
        end
        rn   = (fld_q == F_F) ? freg : xreg;
        tens = (rn >= 5'd30) ? 2'd3 : (rn >= 5'd20) ? 2'd2 : (rn >= 5'd10) ? 2'd1 : 2'd0;
        ones = rn - {tens, 3'b000} - {2'b00, tens, 1'b0};

        // Leading-zero suppression: start at the highest nonzero BCD digit.
        ord_top = '0;
        for (int i = 0; i < 10; i++)
            if (order_q[4*i +: 4] != 4'd0) ord_top = 4'(i);

        order_inc = order_q;
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || order_q[4*(i-1) +: 4] == 4'd9 && order_inc[4*(i-1) +: 4] == 4'd0)
                order_inc[4*i +: 4] = (order_q[4*i +: 4] == 4'd9) ? 4'd0 : order_q[4*i +: 4] + 4'd1;
        end

        cur_val = '0;
        vstart  = '0;
        case (fld_q)
            F_ORDER: begin cur_val[39:0] = order_q;  vstart = ord_top; end
            F_INSN:  begin cur_val[31:0] = insn_q;   vstart = 4'd7;    end
            F_PC:    begin cur_val[XLEN-1:0] = pc_q; vstart = XTOP;    end
            F_MODE:  cur_val[1:0] = mode_q;
            F_TRAP:  cur_val[0] = trap_q;
            F_X:     begin cur_val[XLEN-1:0] = xd_q[int'(xreg)*XLEN +: XLEN]; vstart = XTOP; end
            default: begin cur_val[FLEN-1:0] = fd_q[int'(freg)*FLEN +: FLEN]; vstart = FTOP; end
        endcase
        nib = cur_val[4*didx_q +: 4];

        rem_x = xm_q;
        rem_f = fm_q;
        if (fld_q == F_X) rem_x[xreg] = 1'b0;
        if (fld_q == F_F) rem_f[freg] = 1'b0;

        // Keys are left-aligned in a 5-character window.
        case (fld_q)
            F_ORDER: begin kstr = "ORDER";          klast = 3'd4; end
            F_INSN:  begin kstr = {"INSN", 8'h00};  klast = 3'd3; end
            F_PC:    begin kstr = {"PC", 24'h0};    klast = 3'd1; end
            F_MODE:  begin kstr = {"MODE", 8'h00};  klast = 3'd3; end
            F_TRAP:  begin kstr = {"TRAP", 8'h00};  klast = 3'd3; end
            F_X:     begin kstr = {"X", 32'h0};     klast = 3'd0; end
            default: begin kstr = {"F", 32'h0};     klast = 3'd0; end
        endcase

        case (state_q)
            S_KEY:    out_data_c = kstr[8*(4 - int'(kidx_q)) +: 8];
            S_SPACE:  out_data_c = 8'h20;
            S_REGNUM: out_data_c = hexch(didx_q[0] ? {2'b00, tens} : ones[3:0]);
            S_VALUE:  out_data_c = hexch(nib);
            S_EOL:    out_data_c = 8'h0a;
            default:  out_data_c = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        fld_d   = fld_q;
        kidx_d  = kidx_q;
        didx_d  = didx_q;
        aft_d   = aft_q;
        xm_d    = xm_q;
        fm_d    = fm_q;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_KEY;
                fld_d   = F_ORDER;
                kidx_d  = '0;
                xm_d    = bus.x_wb & 32'hffff_fffe;
                fm_d    = bus.f_wb;
            end
            S_KEY: if (hs) begin
                if (kidx_q == klast) begin
                    state_d = S_SPACE;
                    aft_d   = (fld_q == F_X || fld_q == F_F) ? A_REG : A_VAL;
                end else begin
                    kidx_d = kidx_q + 3'd1;
                end
            end
            S_SPACE: if (hs) begin
                case (aft_q)
                    A_KEY:   begin state_d = S_KEY;    kidx_d = '0; end
                    A_REG:   begin state_d = S_REGNUM; didx_d = (rn >= 5'd10) ? 4'd1 : 4'd0; end
                    default: begin state_d = S_VALUE;  didx_d = vstart; end
                endcase
            end
            S_REGNUM: if (hs) begin
                if (didx_q == 4'd0) begin
                    state_d = S_SPACE;
                    aft_d   = A_VAL;
                end else begin
                    didx_d = didx_q - 4'd1;
                end
            end
            S_VALUE: if (hs) begin
                if (didx_q == 4'd0) begin
                    // Field done: retire its mask bit, then pick the next field.
                    xm_d    = rem_x;
                    fm_d    = rem_f;
                    state_d = S_SPACE;
                    aft_d   = A_KEY;
                    if (fld_q < F_TRAP)  fld_d = fld_q + 3'd1;
                    else if (rem_x != 0) fld_d = F_X;
                    else if (rem_f != 0) fld_d = F_F;
                    else                 state_d = S_EOL;
                end else begin
                    didx_d = didx_q - 4'd1;
                end
            end
            S_EOL: if (hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            fld_q   <= F_ORDER;
            kidx_q  <= '0;
            didx_q  <= '0;
            aft_q   <= A_KEY;
            order_q <= '0;
        end else begin
            state_q <= state_d;
            fld_q   <= fld_d;
            kidx_q  <= kidx_d;
            didx_q  <= didx_d;
            aft_q   <= aft_d;
            if (state_q == S_EOL && hs) order_q <= order_inc;
        end
    end

    always_ff @(posedge clk) begin
        xm_q <= xm_d;
        fm_q <= fm_d;
        if (accept) begin
            insn_q <= bus.insn;
            pc_q   <= bus.pc_rdata;
            mode_q <= bus.mode;
            trap_q <= bus.trap;
            xd_q   <= bus.x_wdata;
            fd_q   <= bus.f_wdata;
        end
    end
endmodule

// File: tb/tb_rvvi_trace_writer.sv
// Directed bench for rvvi_trace_writer: 32-bit instance for line format,
// backpressure, ORDER counting/wrap and reset; 64-bit instance for wide values.
module tb_rvvi_trace_writer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rvvi_trace_writer_if #(.XLEN(32), .FLEN(32)) b32 ();
    rvvi_trace_writer_if #(.XLEN(64), .FLEN(64)) b64 ();

    rvvi_trace_writer #(.XLEN(32), .FLEN(32)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));
    rvvi_trace_writer #(.XLEN(64), .FLEN(64)) u64 (.clk(clk), .reset(reset), .bus(b64.slave));

    task automatic chk(input string tag, input string got, input string exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", tag, got, exp);
        end
    endtask

    task automatic set_min();
        b32.insn     = 32'h0000_0013;
        b32.pc_rdata = 32'h8000_0000;
        b32.mode     = 2'd3;
        b32.trap     = 1'b0;
        b32.x_wb     = '0;
        b32.x_wdata  = '0;
        b32.f_wb     = '0;
        b32.f_wdata  = '0;
    endtask

    function automatic string min_line(input string ord);
        return $sformatf("ORDER %s INSN 00000013 PC 80000000 MODE 3 TRAP 0\n", ord);
    endfunction

    // Offers the current b32 record, then gathers handshaken bytes until "\n"
    // or stop_after bytes. Returns at the negedge of the final byte.
    task automatic run_line(input bit bp, input int stop_after,
                            output string s, output int ncyc, output int nlast);
        int guard = 0;
        bit done = 0;
        bit stalled = 0;
        logic [8:0] prev = '0;
        s = "";
        ncyc = 0;
        nlast = 0;
        @(negedge clk);
        while (!b32.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!b32.in_ready) chk("in_ready_timeout", "0", "1");
        b32.in_valid = 1'b1;
        @(posedge clk);
        #1 b32.in_valid = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (stalled)
                chk("stall_hold", $sformatf("%h", {b32.out_last, b32.out_data}), $sformatf("%h", prev));
            b32.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            ncyc++;
            if (b32.out_valid && b32.out_ready) begin
                s = $sformatf("%s%c", s, b32.out_data);
                if (b32.out_last) nlast++;
                if (b32.out_last || s.len() == stop_after) done = 1;
            end
            stalled = b32.out_valid && !b32.out_ready;
            prev    = {b32.out_last, b32.out_data};
        end
        if (!done) chk("line_timeout", s, "<complete line>");
        b32.out_ready = 1'b1;
    endtask

    initial begin
        string s, s64;
        int ncyc, nlast, g;
        bit d64;

        b32.in_valid = 1'b0; b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.out_ready = 1'b1;
        set_min();
        b64.insn = '0; b64.pc_rdata = '0; b64.mode = '0; b64.trap = '0;
        b64.x_wb = '0; b64.x_wdata = '0; b64.f_wb = '0; b64.f_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", $sformatf("%b %b %h %b", b32.in_ready, b32.out_valid, b32.out_data, b32.out_last),
            "0 0 00 0");
        reset = 1'b0;
        #1;
        chk("in_ready_after_reset", $sformatf("%b", b32.in_ready), "1");

        run_line(0, 0, s, ncyc, nlast);
        chk("minimal_line", s, min_line("0"));
        chk("minimal_len", $sformatf("%0d", s.len()), "48");
        chk("minimal_cycles", $sformatf("%0d", ncyc), "48");
        chk("minimal_nlast", $sformatf("%0d", nlast), "1");
        @(negedge clk);
        chk("in_ready_after_eol", $sformatf("%b", b32.in_ready), "1");

        b32.insn = 32'h1234_5abc;
        b32.pc_rdata = 32'h8000_0004;
        b32.mode = 2'd0;
        b32.trap = 1'b1;
        b32.x_wb = 32'h0002_0021;
        b32.x_wdata[0 +: 32]     = 32'hffff_ffff;
        b32.x_wdata[5*32 +: 32]  = 32'hdead_beef;
        b32.x_wdata[17*32 +: 32] = 32'h0000_0001;
        b32.f_wb = 32'h8000_0000;
        b32.f_wdata[31*32 +: 32] = 32'h3f80_0000;
        run_line(0, 0, s, ncyc, nlast);
        chk("regs_line", s,
            "ORDER 1 INSN 12345abc PC 80000004 MODE 0 TRAP 1 X 5 deadbeef X 17 00000001 F 31 3f800000\n");
        chk("regs_no_bubbles", $sformatf("%0d", ncyc), $sformatf("%0d", s.len()));

        run_line(1, 0, s, ncyc, nlast);
        chk("backpressure_line", s,
            "ORDER 2 INSN 12345abc PC 80000004 MODE 0 TRAP 1 X 5 deadbeef X 17 00000001 F 31 3f800000\n");

        set_min();
        for (int n = 3; n <= 10; n++) begin
            run_line(0, 0, s, ncyc, nlast);
            chk($sformatf("order_line_%0d", n), s, min_line($sformatf("%0d", n)));
        end

        @(negedge clk);
        force u32.order_q = 40'h99_9999_9999;
        @(negedge clk);
        release u32.order_q;
        run_line(0, 0, s, ncyc, nlast);
        chk("order_max", s, min_line("9999999999"));
        run_line(0, 0, s, ncyc, nlast);
        chk("order_wrap", s, min_line("0"));

        run_line(0, 20, s, ncyc, nlast);
        chk("partial_bytes", s, "ORDER 1 INSN 0000001");
        reset = 1'b1;
        @(negedge clk);
        chk("reset_midline", $sformatf("%b %b %b", b32.out_valid, b32.out_last, b32.in_ready), "0 0 0");
        reset = 1'b0;
        run_line(0, 0, s, ncyc, nlast);
        chk("after_reset_line", s, min_line("0"));

        b64.insn = 32'h0000_0013;
        b64.pc_rdata = 64'h0000_0000_8000_1000;
        b64.mode = 2'd3;
        b64.x_wb = 32'h0000_0002;
        b64.x_wdata[64 +: 64] = 64'h0000_0000_0000_00ff;
        b64.f_wb = 32'h0000_0001;
        b64.f_wdata[0 +: 64] = 64'h0123_4567_89ab_cdef;
        @(negedge clk);
        b64.in_valid = 1'b1;
        @(posedge clk);
        #1 b64.in_valid = 1'b0;
        s64 = "";
        d64 = 0;
        g = 0;
        while (!d64 && g < 500) begin
            @(negedge clk);
            g++;
            if (b64.out_valid) begin
                s64 = $sformatf("%s%c", s64, b64.out_data);
                if (b64.out_last) d64 = 1;
            end
        end
        chk("xlen64_line", s64,
            "ORDER 0 INSN 00000013 PC 0000000080001000 MODE 3 TRAP 0 X 1 00000000000000ff F 0 0123456789abcdef\n");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
